// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
// Groups the two requester command/response ports and the RAM-side bus of the
// RAM arbiter.
//
// Handshake: port k presents a command by raising i_reqk with i_wek, i_addrk
// and i_wdatak stable. The command is accepted in the cycle o_gntk is high.
// i_reqk may drop before a grant, and the command is then never issued.
// Reads return o_rdatak with a one-cycle o_rvalidk pulse three cycles after
// the grant. There is no backpressure on the response path.
//
// Modports:
//   slave  - the arbiter: consumes requests and RAM read data, drives the rest.
//   master - the environment: requesters plus the RAM model.
// Debug: o_dbg_owner / o_dbg_count expose the arbitration state.
// -----------------------------------------------------------------------------
interface ram_arbiter_if #(
   parameter int g_RAM_WIDTH = 11,
   parameter int g_RAM_ADDR  = 9
);
   logic                   i_req0;
   logic                   i_req1;
   logic                   i_we0;
   logic                   i_we1;
   logic [g_RAM_ADDR-1:0]  i_addr0;
   logic [g_RAM_ADDR-1:0]  i_addr1;
   logic [g_RAM_WIDTH-1:0] i_wdata0;
   logic [g_RAM_WIDTH-1:0] i_wdata1;
   logic                   o_gnt0;
   logic                   o_gnt1;
   logic                   o_rvalid0;
   logic                   o_rvalid1;
   logic [g_RAM_WIDTH-1:0] o_rdata0;
   logic [g_RAM_WIDTH-1:0] o_rdata1;
   logic                   o_ram_en;
   logic                   o_ram_we;
   logic                   o_ram_re;
   logic [g_RAM_ADDR-1:0]  o_ram_addr;
   logic [g_RAM_WIDTH-1:0] o_ram_data;
   logic [g_RAM_WIDTH-1:0] i_ram_data;
   logic                   o_dbg_owner;
   logic [3:0]             o_dbg_count;

   modport slave (
      input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
             i_wdata0, i_wdata1, i_ram_data,
      output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
             o_ram_en, o_ram_we, o_ram_re, o_ram_addr, o_ram_data,
             o_dbg_owner, o_dbg_count
   );

   modport master (
      output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
             i_wdata0, i_wdata1, i_ram_data,
      input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
             o_ram_en, o_ram_we, o_ram_re, o_ram_addr, o_ram_data,
             o_dbg_owner, o_dbg_count
   );
endinterface

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares a single-port data RAM between port 0 (CPU load/store) and port 1
// (debug/DMA loader). Round-robin arbitration with a bounded burst: the port
// that currently owns the RAM keeps it for at most g_MAX_BURST consecutive
// grants while the other port is waiting.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   arb_if   - slave modport: req/gnt commands, read responses, RAM bus,
//              debug view of owner/burst count
//
// Timing: grant in cycle N (combinational), RAM access registered at edge
// N+1, RAM data sampled at edge N+3 giving o_rvalidk in cycle N+3.
// -----------------------------------------------------------------------------
module ram_arbiter #(
   parameter int g_RAM_WIDTH = 11,
   parameter int g_RAM_ADDR  = 9,
   parameter int g_MAX_BURST = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   ram_arbiter_if.slave  arb_if
);

   localparam logic [3:0] c_MAX = 4'(g_MAX_BURST);

   // arbitration state
   logic       owner_q, owner_d;
   logic [3:0] count_q, count_d;

   // grant decision
   logic       gnt_any;
   logic       gnt_port;

   // selected command
   logic                   sel_we;
   logic [g_RAM_ADDR-1:0]  sel_addr;
   logic [g_RAM_WIDTH-1:0] sel_wdata;

   // RAM issue registers
   logic                   ram_en_q, ram_we_q, ram_re_q;
   logic [g_RAM_ADDR-1:0]  ram_addr_q;
   logic [g_RAM_WIDTH-1:0] ram_data_q;

   // read tag pipeline {valid, port}
   logic tag1_vld_q, tag1_port_q;
   logic tag2_vld_q, tag2_port_q;

   // response registers
   logic                   rvalid0_q, rvalid1_q;
   logic [g_RAM_WIDTH-1:0] rdata0_q, rdata1_q;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         owner_q <= 1'b0;
         count_q <= 4'd0;
      end else begin
         owner_q <= owner_d;
         count_q <= count_d;
      end
   end

   // ---------------------------------------------------------- next state comb
   always_comb begin
      owner_d = owner_q;
      count_d = count_q;
      if (gnt_any) begin
         if (gnt_port == owner_q) begin
            if (count_q < c_MAX) begin
               count_d = count_q + 4'd1;
            end
         end else begin
            owner_d = gnt_port;
            count_d = 4'd1;
         end
      end
   end

   // -------------------------------------------------------------- output comb
   // Grants are suppressed while reset is held so no command slips through.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_port = 1'b0;
      if (i_rst_n) begin
         if (arb_if.i_req0 && arb_if.i_req1) begin
            gnt_any  = 1'b1;
            gnt_port = (count_q < c_MAX) ? owner_q : ~owner_q;
         end else if (arb_if.i_req0) begin
            gnt_any  = 1'b1;
            gnt_port = 1'b0;
         end else if (arb_if.i_req1) begin
            gnt_any  = 1'b1;
            gnt_port = 1'b1;
         end
      end
   end

   assign arb_if.o_gnt0      = gnt_any & ~gnt_port;
   assign arb_if.o_gnt1      = gnt_any &  gnt_port;
   assign arb_if.o_dbg_owner = owner_q;
   assign arb_if.o_dbg_count = count_q;

   assign sel_we    = gnt_port ? arb_if.i_we1    : arb_if.i_we0;
   assign sel_addr  = gnt_port ? arb_if.i_addr1  : arb_if.i_addr0;
   assign sel_wdata = gnt_port ? arb_if.i_wdata1 : arb_if.i_wdata0;

   // ---------------------------------------------------------------- RAM issue
   // Address/data hold when idle so the RAM bus only toggles on real accesses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ram_en_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_re_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
      end else begin
         ram_en_q <= gnt_any;
         ram_we_q <= gnt_any & sel_we;
         ram_re_q <= gnt_any & ~sel_we;
         if (gnt_any) begin
            ram_addr_q <= sel_addr;
            ram_data_q <= sel_wdata;
         end
      end
   end

   // ------------------------------------------------------------ read return
   // The tag travels two stages so it lines up with the RAM's one-cycle read
   // data; reset clears it, which drops any read that was in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tag1_vld_q  <= 1'b0;
         tag1_port_q <= 1'b0;
         tag2_vld_q  <= 1'b0;
         tag2_port_q <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         tag1_vld_q  <= gnt_any & ~sel_we;
         tag1_port_q <= gnt_port;
         tag2_vld_q  <= tag1_vld_q;
         tag2_port_q <= tag1_port_q;
         rvalid0_q   <= tag2_vld_q & ~tag2_port_q;
         rvalid1_q   <= tag2_vld_q &  tag2_port_q;
         if (tag2_vld_q && !tag2_port_q) begin
            rdata0_q <= arb_if.i_ram_data;
         end
         if (tag2_vld_q && tag2_port_q) begin
            rdata1_q <= arb_if.i_ram_data;
         end
      end
   end

   assign arb_if.o_ram_en   = ram_en_q;
   assign arb_if.o_ram_we   = ram_we_q;
   assign arb_if.o_ram_re   = ram_re_q;
   assign arb_if.o_ram_addr = ram_addr_q;
   assign arb_if.o_ram_data = ram_data_q;
   assign arb_if.o_rvalid0  = rvalid0_q;
   assign arb_if.o_rvalid1  = rvalid1_q;
   assign arb_if.o_rdata0   = rdata0_q;
   assign arb_if.o_rdata1   = rdata1_q;

endmodule
